// File: rtl/aes_inv_pkg.sv
// Shared AES tables, FSM state type and key-schedule helpers for the
// iterative AES-128 decryption core.
package aes_inv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DECRYPT,
    DONE
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Out-of-range indices (idle counter values) map to zero.
  function automatic logic [7:0] rcon_byte(input logic [3:0] i);
    if (i >= 4'd1 && i <= 4'd10) return RCON[i];
    return 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Recovers the previous round key from the next one; word 3 must be
  // rebuilt first because word 0 depends on it.
  function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, round-key xor,
// then InvMixColumns unless last_i marks the final round.
module aes_inv_round
  import aes_inv_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [7:0] b  [16];
  logic [7:0] ark[16];
  logic [7:0] mc [16];

  always_comb begin
    for (int n = 0; n < 16; n++) b[n] = state_i[127-8*n -: 8];

    // Byte n sits at row n%4, column n/4; row r rotates right by r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[4*c+r] = INV_SBOX[b[4*((c - r + 4) % 4) + r]] ^ rk_i[127-8*(4*c+r) -: 8];
      end
    end

    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = gmul(ark[4*c], 8'h0e) ^ gmul(ark[4*c+1], 8'h0b) ^ gmul(ark[4*c+2], 8'h0d) ^ gmul(ark[4*c+3], 8'h09);
      mc[4*c+1] = gmul(ark[4*c], 8'h09) ^ gmul(ark[4*c+1], 8'h0e) ^ gmul(ark[4*c+2], 8'h0b) ^ gmul(ark[4*c+3], 8'h0d);
      mc[4*c+2] = gmul(ark[4*c], 8'h0d) ^ gmul(ark[4*c+1], 8'h09) ^ gmul(ark[4*c+2], 8'h0e) ^ gmul(ark[4*c+3], 8'h0b);
      mc[4*c+3] = gmul(ark[4*c], 8'h0b) ^ gmul(ark[4*c+1], 8'h0d) ^ gmul(ark[4*c+2], 8'h09) ^ gmul(ark[4*c+3], 8'h0e);
    end

    state_o = '0;
    for (int n = 0; n < 16; n++) state_o[127-8*n -: 8] = last_i ? ark[n] : mc[n];
  end

endmodule

// File: rtl/aes_128_inv.sv
// Iterative AES-128 decryptor: forward key walk to rk10, then ten inverse
// rounds unwinding the schedule. Optional key cache: AES_INV_KEY_CACHE_EN.
module aes_128_inv
  import aes_inv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] ct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt
);

  state_t       state_q, state_d;
  logic [127:0] s_q, s_d;
  logic [127:0] k_q, k_d;
  logic [3:0]   rc_q, rc_d;
  logic [127:0] k_fwd, k_inv, round_out;

  assign k_fwd = fwd_key_step(k_q, rcon_byte(rc_q));
  assign k_inv = inv_key_step(k_q, rcon_byte(4'd11 - rc_q));

  aes_inv_round u_round (
    .state_i (s_q),
    .rk_i    (k_inv),
    .last_i  (rc_q == 4'd10),
    .state_o (round_out)
  );

`ifdef AES_INV_KEY_CACHE_EN
  logic         cache_valid_q, cache_valid_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_rk_q, cache_rk_d;
  logic         cache_hit;

  assign cache_hit = cache_valid_q && (key == cache_key_q);

  // A miss invalidates the entry until its rk10 is known at the end of EXPAND.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_key_d   = cache_key_q;
    cache_rk_d    = cache_rk_q;
    if (state_q == IDLE && in_valid && !cache_hit) begin
      cache_valid_d = 1'b0;
      cache_key_d   = key;
    end else if (state_q == EXPAND && rc_q == 4'd10) begin
      cache_valid_d = 1'b1;
      cache_rk_d    = k_fwd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cache_valid_q <= 1'b0;
    else      cache_valid_q <= cache_valid_d;
  end

  // NOTE: the cache payload is qualified by cache_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    cache_key_q <= cache_key_d;
    cache_rk_q  <= cache_rk_d;
  end
`endif

  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    rc_d    = rc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef AES_INV_KEY_CACHE_EN
          if (cache_hit) begin
            s_d     = ct ^ cache_rk_q;
            k_d     = cache_rk_q;
            rc_d    = 4'd1;
            state_d = DECRYPT;
          end else
`endif
          begin
            s_d     = ct;
            k_d     = key;
            rc_d    = 4'd1;
            state_d = EXPAND;
          end
        end
      end
      EXPAND: begin
        k_d = k_fwd;
        if (rc_q == 4'd10) begin
          s_d     = s_q ^ k_fwd;
          rc_d    = 4'd1;
          state_d = DECRYPT;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      DECRYPT: begin
        s_d = round_out;
        k_d = k_inv;
        if (rc_q == 4'd10) state_d = DONE;
        else               rc_d    = rc_q + 4'd1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      rc_q    <= rc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign pt        = s_q;

endmodule

// File: tb/tb_aes_128_inv.sv
// Directed self-checking bench for aes_128_inv using FIPS-197 vectors;
// latency expectations follow AES_INV_KEY_CACHE_EN when it is defined.
module tb_aes_128_inv;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] ct;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] R1  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;

`ifdef AES_INV_KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 21;
`endif

  always #5 clk = ~clk;

  aes_128_inv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .ct        (ct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction; latency counted in cycles from the accept edge.
  task automatic txn(input string tag, input logic [127:0] k_in, input logic [127:0] c_in,
                     input logic [127:0] p_exp, input logic [127:0] rk_exp, input int lat_exp,
                     input bit noise, input bit early, input bit hold);
    int lat;
    @(negedge clk);
    key       = k_in;
    ct        = c_in;
    in_valid  = 1'b1;
    out_ready = early;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (noise && !out_valid) begin
        in_valid = ~in_valid;
        ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        in_valid = 1'b0;
      end
      if (lat == 11 && rk_exp !== '0) check({tag, "_rk10"}, dut.k_q, rk_exp);
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    check({tag, "_latency"}, 128'(lat), 128'(lat_exp));
    check({tag, "_pt"}, pt, p_exp);
    check({tag, "_in_ready_busy"}, 128'(in_ready), 128'(0));
    if (!early) begin
      if (hold) begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check({tag, "_hold"}, {out_valid, in_ready, pt}, {1'b1, 1'b0, p_exp});
        end
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, 128'(in_ready), 128'(1));
    check({tag, "_out_valid_after"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    bit seen;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    key       = '0;
    ct        = '0;
    #12;
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_pt", pt, '0);
    @(negedge clk);
    rst = 1'b1;

    txn("fips_b", K1, C1, P1, R1, 21, 1'b0, 1'b0, 1'b1);
    txn("fips_c1_early", K2, C2, P2, '0, 21, 1'b0, 1'b1, 1'b0);
    txn("noise", K1, C1, P1, '0, 21, 1'b1, 1'b0, 1'b0);

    // Abort at DECRYPT round 5 (15 cycles after accept).
    @(negedge clk);
    key      = K2;
    ct       = C2;
    in_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("abort_round5_rc", 128'(dut.rc_q), 128'(5));
    rst = 1'b0;
    #1;
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_pt", pt, '0);
    check("abort_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_output", 128'(seen), 128'(0));

    txn("after_reset", K2, C2, P2, '0, 21, 1'b0, 1'b0, 1'b0);
    txn("same_key", K2, C2, P2, '0, HIT_LAT, 1'b0, 1'b0, 1'b0);
    txn("new_key", K1, C1, P1, '0, 21, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
